quad_tachometer: RTL and testbench
==================================

# quad_tachometer

Multi-channel quadrature encoder tachometer for the motor-control peripheral. Each channel decodes an A/B encoder pair at 4x resolution into a signed, direction-aware edge count. All channels share one gate timer. At the end of every gate window each channel's count is latched to its output register, together with an overflow flag and a quadrature-error count. It is the parametrised successor of the single-input, positive-edge-only tachometer and feeds the same AXI register bank and PID loop.

## Interface
- `CLOCK_FREQ`, default 100000000: system clock frequency in Hz; documentation and derivation only.
- `GATE_CLOCKS`, default CLOCK_FREQ: gate window length in clock cycles; must be ≥ 4.
- `NUM_CH`, default 2: number of encoder channels, 1..8.
- `COUNT_W`, default 16: signed count width per channel, 8..32.
- `DEBOUNCE_CLOCKS`, default 8: filter length; used only with TACH_DEBOUNCE_EN.
- `clock`, input, 1: system clock, all logic on rising edge.
- `system_reset`, input, 1: synchronous, active-high reset.
- `enc_a`, input, NUM_CH: encoder phase A per channel; asynchronous.
- `enc_b`, input, NUM_CH: encoder phase B per channel; asynchronous.
- `count_out`, output, NUM_CH*COUNT_W: latched signed counts; channel n occupies bits [n*COUNT_W +: COUNT_W].
- `dir_out`, output, NUM_CH: direction of the last valid transition; 1 = forward (A leads B).
- `ovf_out`, output, NUM_CH: set if the channel saturated during the latched window.
- `err_out`, output, NUM_CH*8: latched per-window count of illegal transitions, saturating at 255.
- `sample_valid`, output, 1: one-cycle pulse when new latched values appear.

## Operation
- **Input path.** enc_a and enc_b pass through a 2-flop synchronizer per bit. A third register holds the previous AB state.
- **Decode.** Compare prev AB with current AB using Gray order 00→01→11→10→00.
  - Forward step: +1.
  - Reverse step: −1.
  - No change: 0.
  - Both bits changed: illegal. Accumulator unchanged, error counter +1, dir unchanged.
- **Accumulator.** COUNT_W-bit signed per channel, saturating at +2^(COUNT_W−1)−1 and −2^(COUNT_W−1). A step that would exceed a limit holds the limit and sets the channel's window overflow flag.
- **Gate counter.** Counts 0..GATE_CLOCKS−1 and wraps, so the window is exactly GATE_CLOCKS cycles.
- **End-of-gate cycle (gate counter = GATE_CLOCKS−1).** For every channel:
  - count_out ← accumulator plus that cycle's step (saturated).
  - ovf_out ← window flag, including any overflow in that cycle.
  - err_out ← error counter, including that cycle's error.
  - The accumulator, window flag and error counter then restart at 0, so the end-of-gate event belongs to the closing window.
- **dir_out** updates on every valid step; it is not gated.
- **Reset.** Applies on any cycle, including mid-window. Everything clears to 0: count_out, dir_out, ovf_out, err_out, sample_valid, accumulators, gate counter, synchronizers and prev-state registers. The first window after reset is a full GATE_CLOCKS long.
- **Power-up edge.** The prev-state register loads from the synchronizer on the first post-reset cycle with no step counted, so static input levels at reset produce no spurious count.

## Timing
- Pin change to accumulator update: 3 cycles (2 sync + decode register).
- Output registers update on the cycle after gate counter = GATE_CLOCKS−1. sample_valid pulses high on that same cycle, for exactly 1 cycle.
- Output period: GATE_CLOCKS cycles exactly. No back-pressure; consumers must sample on sample_valid.
- Maximum countable edge rate: 1 state change per clock per channel after the synchronizer.

## Configuration
- **`TACH_DEBOUNCE_EN` defined:** each synchronized A/B bit passes through a stability filter. A new level is accepted only after DEBOUNCE_CLOCKS consecutive equal samples, adding DEBOUNCE_CLOCKS cycles of latency. Glitches shorter than that are dropped and produce neither counts nor errors.
- **Undefined:** no filter; latency is 3 cycles and DEBOUNCE_CLOCKS is ignored.

## Structure
- **Package `tach_pkg`:**
  - typedef `quad_state_t` (2-bit AB).
  - enum `step_t` {STEP_NONE, STEP_FWD, STEP_REV, STEP_ERR}.
  - function `quad_decode(prev, cur)` returning step_t.
  - constant `ERR_W = 8`.
- **Sub-module `tach_channel`:** synchronizer, optional filter, decoder, saturating accumulator and error counter for one channel. It takes a gate_end strobe input. The top level holds the gate counter, instantiates NUM_CH channels via generate, and drives sample_valid.

## Test plan
Bench uses GATE_CLOCKS=100, NUM_CH=2, COUNT_W=8.
1. **Forward rotation:** ch0 forward step every 4 cycles, ch1 idle → after second window, count_out ch0=25, ch1=0, dir_out[0]=1, sample_valid pulse every 100 cycles.
2. **Reverse rotation:** ch1 reverse, 10 steps per window → ch1 count=−10 (0xF6), dir_out[1]=0, err=0.
3. **Illegal transitions:** drive AB 00→11 on ch0 three times in one window → err ch0=3, count unchanged by those events.
4. **Saturation:** 200 forward steps in one window → count=127, ovf_out[0]=1. Next window with 5 steps → count=5, ovf=0.
5. **Boundary and reset:** a step landing on the end-of-gate cycle is counted in the closing window. Assert system_reset at cycle 50 of a window → all outputs 0 next cycle, next sample_valid exactly 100 cycles after reset release +1.
6. **Debounce (`TACH_DEBOUNCE_EN` build):** 3-cycle glitch on enc_a → no count and no error. Clean edge → counted after DEBOUNCE_CLOCKS+3 cycles.

Source files
------------

// File: rtl/tach_pkg.sv
// Shared encoder state type, step encoding and quadrature decoder for quad_tachometer.
package tach_pkg;

  localparam int ERR_W = 8;

  // Encoder state packed as {B, A}; forward (A leads B) walks 00 -> 01 -> 11 -> 10 -> 00.
  typedef logic [1:0] quad_state_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_FWD,
    STEP_REV,
    STEP_ERR
  } step_t;

  function automatic quad_state_t quad_next(input quad_state_t s);
    return {s[0], ~s[1]};
  endfunction

  function automatic step_t quad_decode(input quad_state_t prev, input quad_state_t cur);
    step_t r;
    if (prev == cur) begin
      r = STEP_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      r = STEP_ERR;
    end else if (cur == quad_next(prev)) begin
      r = STEP_FWD;
    end else begin
      r = STEP_REV;
    end
    return r;
  endfunction

endpackage

// File: rtl/tach_channel.sv
// One encoder channel: synchronizer, optional glitch filter (TACH_DEBOUNCE_EN),
// quadrature decode, saturating signed accumulator and per-window error counter.
module tach_channel
  import tach_pkg::*;
#(
  parameter int COUNT_W         = 16,
  parameter int DEBOUNCE_CLOCKS = 8
) (
  input  logic               clock_i,
  input  logic               system_reset_i,
  input  logic               enc_a_i,
  input  logic               enc_b_i,
  input  logic               gate_end_i,
  output logic [COUNT_W-1:0] count_o,
  output logic               dir_o,
  output logic               ovf_o,
  output logic [ERR_W-1:0]   err_o
);

  localparam logic signed [COUNT_W-1:0] MAX_V = {1'b0, {(COUNT_W-1){1'b1}}};
  localparam logic signed [COUNT_W-1:0] MIN_V = {1'b1, {(COUNT_W-1){1'b0}}};
  localparam logic signed [COUNT_W-1:0] ONE_V = COUNT_W'(1);
  localparam logic [1:0]                PRIME_LOAD = 2'd3;

  logic [1:0]                sync1_q, sync2_q;
  logic [1:0]                prime_q;
  logic                      priming;
  quad_state_t               prev_q, cur;
  step_t                     step;
  logic signed [COUNT_W-1:0] acc_q, acc_d;
  logic                      ovf_q, ovf_d;
  logic [ERR_W-1:0]          err_q, err_d;
  logic                      dir_q, dir_d;
  logic [COUNT_W-1:0]        count_q;
  logic                      ovf_out_q;
  logic [ERR_W-1:0]          err_out_q;

  // Prev state is seeded from the synchronizer output once the pipeline has filled,
  // so whatever level the pins sit at after reset is never counted as a step.
  assign priming = (prime_q != 2'd0);

`ifdef TACH_DEBOUNCE_EN
  localparam int             DB_W    = $clog2(DEBOUNCE_CLOCKS) + 1;
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CLOCKS - 1);

  logic [1:0]           filt_q;
  logic [1:0][DB_W-1:0] db_cnt_q;

  always_ff @(posedge clock_i) begin
    if (system_reset_i) begin
      filt_q   <= '0;
      db_cnt_q <= {2{DB_LOAD}};
    end else if (priming) begin
      filt_q   <= sync2_q;
      db_cnt_q <= {2{DB_LOAD}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          db_cnt_q[i] <= DB_LOAD;
        end else if (db_cnt_q[i] == '0) begin
          filt_q[i]   <= sync2_q[i];
          db_cnt_q[i] <= DB_LOAD;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] - DB_W'(1);
        end
      end
    end
  end

  assign cur = filt_q;
`else
  assign cur = sync2_q;
`endif

  always_comb begin
    step  = priming ? STEP_NONE : quad_decode(prev_q, cur);
    acc_d = acc_q;
    ovf_d = ovf_q;
    err_d = err_q;
    dir_d = dir_q;
    case (step)
      STEP_FWD: begin
        dir_d = 1'b1;
        if (acc_q == MAX_V) ovf_d = 1'b1;
        else                acc_d = acc_q + ONE_V;
      end
      STEP_REV: begin
        dir_d = 1'b0;
        if (acc_q == MIN_V) ovf_d = 1'b1;
        else                acc_d = acc_q - ONE_V;
      end
      STEP_ERR: begin
        if (err_q != '1) err_d = err_q + ERR_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (system_reset_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prime_q   <= PRIME_LOAD;
      prev_q    <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      err_q     <= '0;
      dir_q     <= 1'b0;
      count_q   <= '0;
      ovf_out_q <= 1'b0;
      err_out_q <= '0;
    end else begin
      sync1_q <= {enc_b_i, enc_a_i};
      sync2_q <= sync1_q;
      if (priming) prime_q <= prime_q - 2'd1;
      prev_q <= priming ? sync2_q : cur;
      dir_q  <= dir_d;
      // The end-of-gate step belongs to the closing window; the new window starts clean.
      if (gate_end_i) begin
        count_q   <= acc_d;
        ovf_out_q <= ovf_d;
        err_out_q <= err_d;
        acc_q     <= '0;
        ovf_q     <= 1'b0;
        err_q     <= '0;
      end else begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
        err_q <= err_d;
      end
    end
  end

  assign count_o = count_q;
  assign dir_o   = dir_q;
  assign ovf_o   = ovf_out_q;
  assign err_o   = err_out_q;

endmodule

// File: rtl/quad_tachometer.sv
// Multi-channel 4x quadrature tachometer with a shared gate window.
// Define TACH_DEBOUNCE_EN to insert a DEBOUNCE_CLOCKS stability filter on every encoder input.
module quad_tachometer
  import tach_pkg::*;
#(
  parameter int CLOCK_FREQ      = 100000000,
  parameter int GATE_CLOCKS     = CLOCK_FREQ,
  parameter int NUM_CH          = 2,
  parameter int COUNT_W         = 16,
  parameter int DEBOUNCE_CLOCKS = 8
) (
  input  logic                      clock,
  input  logic                      system_reset,
  input  logic [NUM_CH-1:0]         enc_a,
  input  logic [NUM_CH-1:0]         enc_b,
  output logic [NUM_CH*COUNT_W-1:0] count_out,
  output logic [NUM_CH-1:0]         dir_out,
  output logic [NUM_CH-1:0]         ovf_out,
  output logic [NUM_CH*ERR_W-1:0]   err_out,
  output logic                      sample_valid
);

  localparam int GATE_W = $clog2(GATE_CLOCKS);

  logic [GATE_W-1:0] gate_q, gate_d;
  logic              gate_end;
  logic              sample_valid_q;

  assign gate_end = (gate_q == GATE_W'(GATE_CLOCKS - 1));
  assign gate_d   = gate_end ? '0 : gate_q + GATE_W'(1);

  always_ff @(posedge clock) begin
    if (system_reset) begin
      gate_q         <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      gate_q         <= gate_d;
      sample_valid_q <= gate_end;
    end
  end

  assign sample_valid = sample_valid_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    tach_channel #(
      .COUNT_W         (COUNT_W),
      .DEBOUNCE_CLOCKS (DEBOUNCE_CLOCKS)
    ) u_ch (
      .clock_i        (clock),
      .system_reset_i (system_reset),
      .enc_a_i        (enc_a[n]),
      .enc_b_i        (enc_b[n]),
      .gate_end_i     (gate_end),
      .count_o        (count_out[n*COUNT_W +: COUNT_W]),
      .dir_o          (dir_out[n]),
      .ovf_o          (ovf_out[n]),
      .err_o          (err_out[n*ERR_W +: ERR_W])
    );
  end

endmodule

// File: tb/tb_quad_tachometer.sv
// Directed bench for quad_tachometer: per-window expectations queued, popped on sample_valid.
`timescale 1ns/1ps
module tb_quad_tachometer;

  localparam int GATE   = 100;
  localparam int NCH    = 2;
  localparam int CW     = 8;
  localparam int DBC    = 8;
  localparam int GATE_S = 400;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              system_reset;
  logic [NCH-1:0]    enc_a, enc_b;
  logic [NCH*CW-1:0] count_out;
  logic [NCH-1:0]    dir_out, ovf_out;
  logic [NCH*8-1:0]  err_out;
  logic              sample_valid;

  logic              sat_reset;
  logic [0:0]        sat_a, sat_b;
  logic [CW-1:0]     sat_count;
  logic [0:0]        sat_dir, sat_ovf;
  logic [7:0]        sat_err;
  logic              sat_valid;

  quad_tachometer #(
    .CLOCK_FREQ(100000000), .GATE_CLOCKS(GATE), .NUM_CH(NCH), .COUNT_W(CW), .DEBOUNCE_CLOCKS(DBC)
  ) dut (
    .clock(clock), .system_reset(system_reset), .enc_a(enc_a), .enc_b(enc_b),
    .count_out(count_out), .dir_out(dir_out), .ovf_out(ovf_out), .err_out(err_out),
    .sample_valid(sample_valid)
  );

  quad_tachometer #(
    .CLOCK_FREQ(100000000), .GATE_CLOCKS(GATE_S), .NUM_CH(1), .COUNT_W(CW), .DEBOUNCE_CLOCKS(DBC)
  ) dut_sat (
    .clock(clock), .system_reset(sat_reset), .enc_a(sat_a), .enc_b(sat_b),
    .count_out(sat_count), .dir_out(sat_dir), .ovf_out(sat_ovf), .err_out(sat_err),
    .sample_valid(sat_valid)
  );

  typedef struct {
    int         id;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] dir;
    logic [1:0] ovf;
    logic [7:0] err0;
    logic [7:0] err1;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_sv = 0;
  int   t0;
  bit   sv_seen;
  int   idx [NCH];
  int   idx_s;

  function automatic logic [1:0] gray(input int i);
    case (i)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] c0, input logic [7:0] c1,
                      input logic [1:0] d, input logic [1:0] o,
                      input logic [7:0] e0, input logic [7:0] e1);
    exp_t e;
    e.id = id; e.cnt0 = c0; e.cnt1 = c1; e.dir = d; e.ovf = o; e.err0 = e0; e.err1 = e1;
    sb_q.push_back(e);
  endtask

  // delta: 1 forward, 3 reverse, 2 illegal (both phases flip)
  task automatic move(input int ch, input int delta);
    logic [1:0] s;
    idx[ch] = (idx[ch] + delta) % 4;
    s = gray(idx[ch]);
    enc_a[ch] = s[0];
    enc_b[ch] = s[1];
  endtask

  task automatic move_s(input int delta);
    logic [1:0] s;
    idx_s = (idx_s + delta) % 4;
    s = gray(idx_s);
    sat_a[0] = s[0];
    sat_b[0] = s[1];
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clock);
    cyc++;
    if (sample_valid === 1'b1) begin
      sv_seen = 1'b1;
      checks++;
      assert (sb_q.size() != 0) else begin
        failures++;
        $error("FAIL sv_unexpected observed=pulse expected=none cyc=%0d", cyc);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk($sformatf("w%0d_cnt0", e.id), count_out[CW-1:0], e.cnt0);
        chk($sformatf("w%0d_cnt1", e.id), count_out[2*CW-1:CW], e.cnt1);
        chk($sformatf("w%0d_dir", e.id), dir_out, e.dir);
        chk($sformatf("w%0d_ovf", e.id), ovf_out, e.ovf);
        chk($sformatf("w%0d_err0", e.id), err_out[7:0], e.err0);
        chk($sformatf("w%0d_err1", e.id), err_out[15:8], e.err1);
        chk($sformatf("w%0d_period", e.id), cyc - last_sv, GATE);
      end
      last_sv = cyc;
    end
  endtask

  task automatic wait_sv(input int budget);
    sv_seen = 1'b0;
    for (int i = 0; i < budget && !sv_seen; i++) tick();
    checks++;
    assert (sv_seen) else begin
      failures++;
      $error("FAIL sv_timeout observed=0 expected=1");
    end
  endtask

  task automatic wait_sat(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (sat_valid !== 1'b1 && n < budget);
    checks++;
    assert (sat_valid === 1'b1) else begin
      failures++;
      $error("FAIL sat_sv_timeout observed=%0b expected=1", sat_valid);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_count"}, count_out, 0);
    chk({pfx, "_dir"}, dir_out, 0);
    chk({pfx, "_ovf"}, ovf_out, 0);
    chk({pfx, "_err"}, err_out, 0);
    chk({pfx, "_sv"}, sample_valid, 0);
  endtask

  initial begin
    system_reset = 1'b1;
    sat_reset    = 1'b1;
    enc_a = '0; enc_b = '0; sat_a = '0; sat_b = '0;
    idx[0] = 0; idx[1] = 0; idx_s = 0;
    repeat (3) tick();
    chk_all_zero("rst");
    system_reset = 1'b0;
    sat_reset    = 1'b0;
    last_sv      = cyc;

`ifdef TACH_DEBOUNCE_EN
    // Glitch on ch1 A is filtered; the following clean step is counted after the filter delay.
    push(0, 8'd0, 8'd1, 2'b10, 2'b00, 8'd0, 8'd0);
    repeat (10) tick();
    enc_a[1] = 1'b1;
    repeat (3) tick();
    enc_a[1] = 1'b0;
    repeat (20) tick();
    move(1, 1);
    t0 = cyc;
    for (int i = 0; i < 30 && dir_out[1] !== 1'b1; i++) tick();
    chk("db_latency", cyc - t0, DBC + 3);
    wait_sv(120);
`else
    // Forward rotation on ch0, one step every 4 cycles.
    push(0, 8'd22, 8'd0, 2'b01, 2'b00, 8'd0, 8'd0);
    push(1, 8'd25, 8'd0, 2'b01, 2'b00, 8'd0, 8'd0);
    repeat (10) tick();
    for (int i = 0; i < 47; i++) begin
      move(0, 1);
      repeat (4) tick();
    end
    wait_sv(10);
    tick();
    chk("sv_one_cycle", sample_valid, 0);

    // Reverse rotation on ch1 (one forward, eleven reverse: net -10).
    push(2, 8'd0, 8'hF6, 2'b01, 2'b00, 8'd0, 8'd0);
    move(1, 1);
    repeat (5) tick();
    chk("dir_fwd_ch1", dir_out[1], 1);
    for (int i = 0; i < 11; i++) begin
      move(1, 3);
      repeat (5) tick();
    end
    wait_sv(60);

    // Illegal transitions on ch0 between two forward steps.
    push(3, 8'd2, 8'd0, 2'b01, 2'b00, 8'd3, 8'd0);
    move(0, 1);
    repeat (5) tick();
    for (int i = 0; i < 3; i++) begin
      move(0, 2);
      repeat (5) tick();
    end
    move(0, 1);
    repeat (5) tick();
    wait_sv(90);

    // Step landing on the end-of-gate cycle closes into this window; one driven later does not.
    push(4, 8'd1, 8'd0, 2'b01, 2'b00, 8'd0, 8'd1);
    repeat (10) tick();
    move(1, 2);
    repeat (87) tick();
    move(0, 1);
    tick();
    move(0, 1);
    wait_sv(10);

    // Mid-window reset, then full window with a latency probe on ch0.
    repeat (50) tick();
    system_reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    system_reset = 1'b0;
    last_sv = cyc;
    push(5, 8'd1, 8'd0, 2'b01, 2'b00, 8'd0, 8'd0);
    repeat (10) tick();
    move(0, 1);
    t0 = cyc;
    for (int i = 0; i < 10 && dir_out[0] !== 1'b1; i++) tick();
    chk("latency_ch0", cyc - t0, 3);
    wait_sv(120);

    // Saturation on a longer-gate instance: 200 steps in one window, then 5.
    system_reset = 1'b1;
    wait_sat(450);
    for (int i = 0; i < 200; i++) begin
      move_s(1);
      @(negedge clock);
    end
    wait_sat(450);
    chk("sat_count", sat_count, 8'h7F);
    chk("sat_ovf", sat_ovf, 1);
    chk("sat_err", sat_err, 0);
    for (int i = 0; i < 5; i++) begin
      move_s(1);
      repeat (2) @(negedge clock);
    end
    wait_sat(450);
    chk("sat_recover_count", sat_count, 8'd5);
    chk("sat_recover_ovf", sat_ovf, 0);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
